// File: rtl/uart_tx.sv
// uart_tx: async-serial transmitter draining a show-ahead FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_read,
  output logic             txd,
  output logic             busy
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           r_state, w_state;
  logic [DW-1:0]    r_div, w_div;
  logic [BW-1:0]    r_bit, w_bit;
  logic [WIDTH-1:0] r_shift, w_shift;
  logic             r_read, w_read;
  logic             r_txd, w_txd;
  logic             r_busy, w_busy;
  logic             w_load;
  logic             w_div_last;
  logic             w_bit_last;
`ifdef UART_TX_PARITY_EN
  logic             r_par, w_par;
`endif

  assign w_div_last = (r_div == DW'(CLKDIV - 1));
  assign w_bit_last = (r_bit == BW'(WIDTH - 1));

  // next state, datapath and the registered-output values they imply
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_load  = 1'b0;
    w_txd   = 1'b1;
    if (r_state != IDLE)
      w_div = w_div_last ? '0 : r_div + DW'(1);
    case (r_state)
      IDLE: w_load = !fifo_empty;
      START: begin
        if (w_div_last) begin
          w_state = DATA;
          w_bit   = '0;
        end
      end
      DATA: begin
        if (w_div_last) begin
          w_shift = r_shift >> 1;
          w_bit   = r_bit + BW'(1);
          if (w_bit_last) begin
            w_bit   = '0;
`ifdef UART_TX_PARITY_EN
            w_state = PARITY;
`else
            w_state = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_div_last)
          w_state = STOP;
      end
`endif
      STOP: begin
        if (w_div_last) begin
          if (!fifo_empty)
            w_load = 1'b1;
          else
            w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    // latching the head word and popping it happen on the same edge
    if (w_load) begin
      w_state = START;
      w_div   = '0;
      w_shift = fifo_rdata;
    end
`ifdef UART_TX_PARITY_EN
    w_par = w_load ? ^fifo_rdata : r_par;
`endif
    case (w_state)
      START:   w_txd = 1'b0;
      DATA:    w_txd = w_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txd = w_par;
`endif
      default: w_txd = 1'b1;
    endcase
    w_read = w_load;
    w_busy = (w_state != IDLE);
  end

  // state and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_read  <= 1'b0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_read  <= w_read;
      r_txd   <= w_txd;
      r_busy  <= w_busy;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

  assign fifo_read = r_read;
  assign txd       = r_txd;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with a behavioural show-ahead FIFO.
// Frames are decoded from txd and scored against an expected-frame queue.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int W   = 8;
  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = W + 3;
`else
  localparam int FB = W + 2;
`endif
  localparam int FC = FB * DIV;
  localparam int NV = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_rdata = '0;
  logic         fifo_read;
  logic         txd;
  logic         busy;

  always #5 clk = ~clk;

  uart_tx #(.WIDTH(W), .CLKDIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_read  (fifo_read),
    .txd        (txd),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // behavioural FIFO: pop lands on the edge after fifo_read is seen
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] push_q[$];
  logic         pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      chk("pop_nonempty", int'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
    pend = fifo_read;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  // frame monitor and scoreboard
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            rd_cnt = 0, busy_cnt = 0, low_cnt = 0;
  int            starts = 0, dones = 0, last_start = -1;
  int            start_q[$];
  logic [FB-1:0] exp_q[$];
  logic          rd_prev = 1'b0;
  bit            mon_on = 1'b0;
  bit            mon_busy_ok = 1'b0;
  int            mon_k = 0;
  logic [FC-1:0] mon_s = '0;

  function automatic void check_frame();
    logic [FB-1:0] got;
    bit stable;
    stable = 1'b1;
    for (int b = 0; b < FB; b++) begin
      got[b] = mon_s[b*DIV];
      for (int j = 1; j < DIV; j++)
        if (mon_s[b*DIV+j] != got[b]) stable = 1'b0;
    end
    chk("bit_hold", int'(stable), 1);
    chk("frame_busy", int'(mon_busy_ok), 1);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_frame: got %0h required none", got);
    end else begin
      chk("frame_bits", int'(got), int'(exp_q.pop_front()));
    end
  endfunction

  always @(negedge clk) begin
    if (fifo_read) begin
      rd_cnt++;
      chk("rd_pulse_width", int'(rd_prev), 0);
    end
    rd_prev = fifo_read;
    if (busy) busy_cnt++;
    if (!txd) low_cnt++;
    if (reset) begin
      mon_on = 1'b0;
    end else begin
      if (!mon_on && !txd) begin
        mon_on = 1'b1;
        mon_k = 0;
        mon_busy_ok = 1'b1;
        starts++;
        last_start = cyc;
        start_q.push_back(cyc);
      end
      if (mon_on) begin
        mon_s[mon_k] = txd;
        if (!busy) mon_busy_ok = 1'b0;
        mon_k++;
        if (mon_k == FC) begin
          mon_on = 1'b0;
          dones++;
          check_frame();
        end
      end
    end
  end

  function automatic logic [FB-1:0] mk_frame(logic [W-1:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [W-1:0] d, logic [FB-1:0] f);
    push_q.push_back(d);
    exp_q.push_back(f);
  endtask

  task automatic wait_dones(int n, int budget);
    int t;
    t = 0;
    while (dones < n && t < budget) begin
      tick(1);
      t++;
    end
    chk("timeout_frames", int'(dones >= n), 1);
  endtask

  task automatic wait_starts(int n, int budget);
    int t;
    t = 0;
    while (starts < n && t < budget) begin
      tick(1);
      t++;
    end
    chk("timeout_starts", int'(starts >= n), 1);
  endtask

  task automatic wait_cyc(int c);
    int t;
    t = 0;
    while (cyc < c && t < 400) begin
      tick(1);
      t++;
    end
    chk("wait_cycle", cyc, c);
  endtask

  typedef struct packed {
    logic [W-1:0] d;
    logic [9:0]   f10;
    logic         par;
  } vec_t;

  vec_t tbl[NV];

  function automatic logic [FB-1:0] tbl_frame(vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.par, v.f10[8:0]};
`else
    return v.f10;
`endif
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int r0, b0, d0, st0, s0, s, rel;
    tbl[0] = '{d: 8'hA5, f10: 10'h34A, par: 1'b0};
    tbl[1] = '{d: 8'h07, f10: 10'h20E, par: 1'b1};
    tbl[2] = '{d: 8'h03, f10: 10'h206, par: 1'b0};
    tbl[3] = '{d: 8'h00, f10: 10'h200, par: 1'b0};
    tbl[4] = '{d: 8'hFF, f10: 10'h3FE, par: 1'b0};
    tbl[5] = '{d: 8'h80, f10: 10'h300, par: 1'b1};

    // reset state and quiet idle
    #2 reset = 1'b1;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_read", fifo_read, 0);
    tick(3);
    reset = 1'b0;
    tick(100);
    chk("idle_reads", rd_cnt, 0);
    chk("idle_starts", starts, 0);
    chk("idle_txd_low", low_cnt, 0);
    chk("idle_busy", busy_cnt, 0);
    chk("idle_txd", txd, 1);

    // single frames from the table
    for (int i = 0; i < NV; i++) begin
      r0 = rd_cnt;
      b0 = busy_cnt;
      d0 = dones;
      push(tbl[i].d, tbl_frame(tbl[i]));
      wait_dones(d0 + 1, 200);
      tick(2);
      chk("tbl_read_pulses", rd_cnt - r0, 1);
      chk("tbl_busy_cycles", busy_cnt - b0, FC);
      chk("tbl_fifo_empty", fifo_empty, 1);
      chk("tbl_txd_idle", txd, 1);
    end

    // three words pushed on consecutive cycles
    r0 = rd_cnt;
    b0 = busy_cnt;
    d0 = dones;
    st0 = start_q.size();
    push(8'h12, mk_frame(8'h12));
    tick(1);
    push(8'h34, mk_frame(8'h34));
    tick(1);
    push(8'h56, mk_frame(8'h56));
    wait_dones(d0 + 3, 600);
    tick(2);
    chk("burst_reads", rd_cnt - r0, 3);
    chk("burst_busy", busy_cnt - b0, 3 * FC);
    chk("burst_gap1", start_q[st0+1] - start_q[st0], FC);
    chk("burst_gap2", start_q[st0+2] - start_q[st0+1], FC);

    // reset during data bit 3, second word survives in the FIFO
    r0 = rd_cnt;
    d0 = dones;
    st0 = starts;
    push(8'hFF, mk_frame(8'hFF));
    tick(1);
    push(8'h0F, mk_frame(8'h0F));
    wait_starts(st0 + 1, 50);
    s = last_start;
    wait_cyc(s + 1 + 4 * DIV);
    chk("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_busy", busy, 0);
    chk("abort_read", fifo_read, 0);
    void'(exp_q.pop_front());
    tick(3);
    reset = 1'b0;
    rel = cyc;
    wait_starts(st0 + 2, 20);
    chk("restart_latency", last_start - rel, 1);
    wait_dones(d0 + 1, 100);
    tick(2);
    chk("abort_reads", rd_cnt - r0, 2);
    chk("abort_fifo_empty", fifo_empty, 1);

    // push in the last stop cycle: no idle gap
    b0 = busy_cnt;
    d0 = dones;
    st0 = start_q.size();
    push(8'h3C, mk_frame(8'h3C));
    wait_starts(st0 + 1, 20);
    s0 = last_start;
    wait_cyc(s0 + FC - 1);
    chk("b2b_pre_empty", fifo_empty, 1);
    push(8'hC3, mk_frame(8'hC3));
    wait_dones(d0 + 2, 200);
    tick(2);
    chk("b2b_gap", start_q[st0+1] - start_q[st0], FC);
    chk("b2b_busy", busy_cnt - b0, 2 * FC);
    chk("scoreboard_drained", exp_q.size(), 0);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
